rv32i_regfile_alu: RTL and testbench
====================================

Name: rv32i_regfile_alu

Overview:
- Execute-side datapath slice for the RV32I multicycle core.
- Contains the 32x32 architectural register file (x0 hardwired to zero) with two asynchronous read ports and one synchronous write port.
- Contains enabled operand registers A/B, a combinational RV32I ALU, and an enabled ALU-result register (alu_last).
- The core FSM drives all enables and selects; this block holds no control state of its own.

Parameters:
- RESET_VALUE, 32'h0, value loaded into every register-file entry, reg_a, reg_b and alu_last on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_ena  in  1  register-file write enable.
- wr_addr  in  5  write index.
- wr_data  in  32  write data.
- rd_addr0  in  5  read index, port 0 (rs1).
- rd_addr1  in  5  read index, port 1 (rs2).
- rd_data0  out  32  combinational read data, port 0.
- rd_data1  out  32  combinational read data, port 1.
- opnd_ena  in  1  capture rd_data0 -> reg_a and rd_data1 -> reg_b.
- imm  in  32  sign-extended immediate.
- alu_src_b_imm  in  1  1: ALU b = imm; 0: ALU b = reg_b.
- alu_control  in  4  alu_control_t operation.
- alu_ena  in  1  capture alu_result -> alu_last.
- reg_a  out  32  operand register A.
- reg_b  out  32  operand register B (also the store-data source).
- alu_result  out  32  combinational ALU result.
- alu_last  out  32  registered ALU result.
- overflow  out  1  signed overflow flag.
- zero  out  1  result == 0.
- equal  out  1  a == b.

Behaviour:
Reset (async, rst=1):
- All 32 file entries, reg_a, reg_b and alu_last take RESET_VALUE immediately, without waiting for a clock edge.
- The register-file entry x0 reads as zero regardless of RESET_VALUE.

Register file:
- Reads are combinational.
- rd_addrN == 0 always returns 0.
- Write on the rising edge when wr_ena=1 and wr_addr != 0. Writes to x0 are discarded.
- No write-to-read bypass: a read in the same cycle as a write to the same index returns the old value until the edge, then the new value.
- Both read ports may address the same index.

Operand and result registers:
- reg_a/reg_b load on a rising edge when opnd_ena=1, otherwise hold. Latency is 1 cycle.
- alu_last loads alu_result on a rising edge when alu_ena=1, otherwise hold.
- Reset takes priority over enables.

ALU (combinational, a = reg_a, b per mux; alu_control_t encoding fixed):
- INVALID 0000 -> 0.
- AND 0001 -> a&b.
- OR 0010 -> a|b.
- XOR 0011 -> a^b.
- SLL 0101 -> a<<b[4:0].
- SRL 0110 -> logical a>>b[4:0].
- SRA 0111 -> arithmetic a>>>b[4:0].
- ADD 1000 -> a+b, mod 2^32.
- SUB 1100 -> a-b, mod 2^32.
- SLT 1101 -> signed a<b ? 1 : 0.
- SLTU 1111 -> unsigned a<b ? 1 : 0.
- Any other code -> 0.
- Shift amounts use only b[4:0]; upper bits are ignored.

Flags:
- overflow: set for ADD when both operands have the same sign and the result sign differs. Set for SUB when operand signs differ and the result sign differs from a. 0 for all other operations.
- zero = (alu_result == 0).
- equal = (a == b), independent of alu_control.

Decomposition:
- Package alu_types: alu_control_t enum with the encodings above.
- Sub-module dff_en: N-bit register with parameters N and RESET, ports clk/rst/ena/d/q, async active-high reset. Instantiate it for reg_a, reg_b and alu_last.
- Register-file storage and the ALU are inline always blocks.

Test Plan:
- Reset: assert rst mid-run after writing x5=0x1234 -> all reads return 0 immediately, before any clock edge; alu_last=0.
- Register file:
  - Write x0=0xDEADBEEF -> rd_data0 for index 0 stays 0.
  - Write x31=0xA5A5A5A5, read both ports at 31 -> both return 0xA5A5A5A5 after the edge and the old value before it.
- ADD/SUB:
  - reg_a=0x7FFFFFFF, reg_b=1, ADD -> 0x80000000, overflow=1.
  - SUB with a=b=5 -> 0, zero=1, equal=1.
  - SUB with a=0x80000000, b=1 -> 0x7FFFFFFF, overflow=1.
- Shifts: a=0x80000000, b=0x24 (b[4:0]=4) -> SRL 0x08000000, SRA 0xF8000000, SLL 0x00000000.
- Compares: a=0xFFFFFFFF, b=1 -> SLT=1, SLTU=0; alu_src_b_imm=1 with imm=0xFFFFFFFF, ADD, a=1 -> 0.
- Enables:
  - opnd_ena=0 -> reg_a/reg_b hold while the file changes.
  - alu_ena pulse -> alu_last updates exactly one edge later, then holds.

Source files
------------

// File: rtl/alu_types.sv
// Shared types for the RV32I execute datapath: ALU operation encodings.
// Latency: none (types only).
// Backpressure: not applicable.
package alu_types;

    typedef enum logic [3:0] {
        ALU_INVALID = 4'b0000,
        ALU_AND     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ADD     = 4'b1000,
        ALU_SUB     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SLTU    = 4'b1111
    } alu_control_t;

endpackage

// File: rtl/dff_en.sv
// N-bit enabled register with asynchronous active-high reset.
// Latency: 1 cycle from d to q when ena is high.
// Backpressure: none; holds q while ena is low.
module dff_en #(
    parameter int          N     = 32,
    parameter logic [N-1:0] RESET = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= RESET;
        else if (ena)
            q <= d;
    end

endmodule

// File: rtl/rv32i_regfile_alu.sv
// RV32I execute slice: 32x32 register file, operand registers, ALU, result register.
// Latency: reads and ALU combinational; operand and result capture take 1 cycle.
// Backpressure: none; the core FSM sequences every enable.
module rv32i_regfile_alu
    import alu_types::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    input  logic        opnd_ena,
    input  logic [31:0] imm,
    input  logic        alu_src_b_imm,
    input  logic [3:0]  alu_control,
    input  logic        alu_ena,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    output logic [31:0] alu_result,
    output logic [31:0] alu_last,
    output logic        overflow,
    output logic        zero,
    output logic        equal
);

    // Entry 0 is never stored; reads of index 0 are forced to zero below.
    logic [31:0] regs [1:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= RESET_VALUE;
        end else if (wr_ena && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'h0 : regs[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : regs[rd_addr1];

    dff_en #(.N(32), .RESET(RESET_VALUE)) u_reg_a (
        .clk (clk),
        .rst (rst),
        .ena (opnd_ena),
        .d   (rd_data0),
        .q   (reg_a)
    );

    dff_en #(.N(32), .RESET(RESET_VALUE)) u_reg_b (
        .clk (clk),
        .rst (rst),
        .ena (opnd_ena),
        .d   (rd_data1),
        .q   (reg_b)
    );

    logic [31:0]  alu_a;
    logic [31:0]  alu_b;
    logic [4:0]   shamt;
    alu_control_t alu_op;

    assign alu_a  = reg_a;
    assign alu_b  = alu_src_b_imm ? imm : reg_b;
    assign shamt  = alu_b[4:0];
    assign alu_op = alu_control_t'(alu_control);

    always_comb begin
        alu_result = 32'h0;
        overflow   = 1'b0;
        case (alu_op)
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_SLL:  alu_result = alu_a << shamt;
            ALU_SRL:  alu_result = alu_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
            ALU_ADD: begin
                alu_result = alu_a + alu_b;
                overflow   = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            ALU_SUB: begin
                alu_result = alu_a - alu_b;
                overflow   = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            ALU_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            ALU_SLTU: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default:  alu_result = 32'h0;
        endcase
    end

    assign zero  = (alu_result == 32'h0);
    assign equal = (alu_a == alu_b);

    dff_en #(.N(32), .RESET(RESET_VALUE)) u_alu_last (
        .clk (clk),
        .rst (rst),
        .ena (alu_ena),
        .d   (alu_result),
        .q   (alu_last)
    );

endmodule

// File: tb/tb_rv32i_regfile_alu.sv
// Directed bench for rv32i_regfile_alu with hand-computed expected values.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled before the next one.
// Backpressure: not applicable.
module tb_rv32i_regfile_alu;

    logic        clk;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data0;
    logic [31:0] rd_data1;
    logic        opnd_ena;
    logic [31:0] imm;
    logic        alu_src_b_imm;
    logic [3:0]  alu_control;
    logic        alu_ena;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic [31:0] alu_result;
    logic [31:0] alu_last;
    logic        overflow;
    logic        zero;
    logic        equal;

    int checks   = 0;
    int failures = 0;

    rv32i_regfile_alu #(.RESET_VALUE(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_ena        (wr_ena),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr0      (rd_addr0),
        .rd_addr1      (rd_addr1),
        .rd_data0      (rd_data0),
        .rd_data1      (rd_data1),
        .opnd_ena      (opnd_ena),
        .imm           (imm),
        .alu_src_b_imm (alu_src_b_imm),
        .alu_control   (alu_control),
        .alu_ena       (alu_ena),
        .reg_a         (reg_a),
        .reg_b         (reg_b),
        .alu_result    (alu_result),
        .alu_last      (alu_last),
        .overflow      (overflow),
        .zero          (zero),
        .equal         (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        wr_ena  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_ena  = 1'b0;
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
        wr(5'd1, a);
        wr(5'd2, b);
        rd_addr0 = 5'd1;
        rd_addr1 = 5'd2;
        opnd_ena = 1'b1;
        tick();
        opnd_ena = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] exp);
        alu_control = op;
        #1;
        check(tag, alu_result, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        wr_ena        = 1'b0;
        wr_addr       = 5'd0;
        wr_data       = 32'h0;
        rd_addr0      = 5'd5;
        rd_addr1      = 5'd31;
        opnd_ena      = 1'b0;
        imm           = 32'h0;
        alu_src_b_imm = 1'b0;
        alu_control   = 4'b0000;
        alu_ena       = 1'b0;
        #1;
        check("rst_rd0", rd_data0, 32'h0);
        check("rst_rega", reg_a, 32'h0);
        check("rst_regb", reg_b, 32'h0);
        check("rst_alu_last", alu_last, 32'h0);
        #2 rst = 1'b0;
        tick();

        wr(5'd5, 32'h0000_1234);
        rd_addr0 = 5'd5;
        #1 check("wr_x5", rd_data0, 32'h0000_1234);

        wr(5'd0, 32'hDEAD_BEEF);
        rd_addr0 = 5'd0;
        #1 check("x0_zero", rd_data0, 32'h0);

        // Same-cycle read of the index being written must see the old value.
        rd_addr0 = 5'd31;
        rd_addr1 = 5'd31;
        wr_ena   = 1'b1;
        wr_addr  = 5'd31;
        wr_data  = 32'hA5A5_A5A5;
        #1;
        check("x31_pre_rd0", rd_data0, 32'h0);
        check("x31_pre_rd1", rd_data1, 32'h0);
        tick();
        wr_ena = 1'b0;
        check("x31_post_rd0", rd_data0, 32'hA5A5_A5A5);
        check("x31_post_rd1", rd_data1, 32'hA5A5_A5A5);

        load_ops(32'h7FFF_FFFF, 32'h1);
        check("op_lat_rega", reg_a, 32'h7FFF_FFFF);
        check("op_lat_regb", reg_b, 32'h1);
        op_check("add_ovf", 4'b1000, 32'h8000_0000);
        check("add_ovf_flag", {31'b0, overflow}, 32'd1);

        load_ops(32'h5, 32'h5);
        op_check("sub_eq", 4'b1100, 32'h0);
        check("sub_eq_zero", {31'b0, zero}, 32'd1);
        check("sub_eq_equal", {31'b0, equal}, 32'd1);
        check("sub_eq_ovf", {31'b0, overflow}, 32'd0);

        load_ops(32'h8000_0000, 32'h1);
        op_check("sub_ovf", 4'b1100, 32'h7FFF_FFFF);
        check("sub_ovf_flag", {31'b0, overflow}, 32'd1);
        check("neq_equal", {31'b0, equal}, 32'd0);

        load_ops(32'h8000_0000, 32'h24);
        op_check("srl", 4'b0110, 32'h0800_0000);
        check("srl_ovf", {31'b0, overflow}, 32'd0);
        op_check("sra", 4'b0111, 32'hF800_0000);
        op_check("sll", 4'b0101, 32'h0000_0000);
        check("sll_zero", {31'b0, zero}, 32'd1);

        load_ops(32'hFFFF_FFFF, 32'h1);
        op_check("slt", 4'b1101, 32'd1);
        op_check("sltu", 4'b1111, 32'd0);
        op_check("and", 4'b0001, 32'h1);
        op_check("or", 4'b0010, 32'hFFFF_FFFF);
        op_check("xor", 4'b0011, 32'hFFFF_FFFE);
        op_check("invalid", 4'b0000, 32'h0);
        op_check("undef_op", 4'b0100, 32'h0);

        load_ops(32'h1, 32'h1);
        alu_src_b_imm = 1'b1;
        imm           = 32'hFFFF_FFFF;
        op_check("add_imm", 4'b1000, 32'h0);
        check("add_imm_zero", {31'b0, zero}, 32'd1);
        check("add_imm_ovf", {31'b0, overflow}, 32'd0);
        alu_src_b_imm = 1'b0;

        wr(5'd1, 32'h0000_0099);
        rd_addr0 = 5'd1;
        #1;
        check("hold_file", rd_data0, 32'h0000_0099);
        check("hold_rega", reg_a, 32'h1);
        check("hold_regb", reg_b, 32'h1);

        // a=1, b=reg_b=1 -> ADD gives 2; capture with a single-cycle pulse.
        alu_control = 4'b1000;
        alu_ena     = 1'b1;
        #1 check("alu_last_pre", alu_last, 32'h0);
        tick();
        alu_ena = 1'b0;
        check("alu_last_post", alu_last, 32'h2);
        alu_control = 4'b1100;
        tick();
        check("alu_last_hold", alu_last, 32'h2);

        rd_addr0 = 5'd5;
        rd_addr1 = 5'd31;
        #1 check("pre_rst_x5", rd_data0, 32'h0000_1234);
        rst = 1'b1;
        #1;
        check("mid_rst_x5", rd_data0, 32'h0);
        check("mid_rst_x31", rd_data1, 32'h0);
        check("mid_rst_rega", reg_a, 32'h0);
        check("mid_rst_alu_last", alu_last, 32'h0);
        #2 rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
